// File: rtl/phy_loopback_emu.sv
// PHY loopback emulator: programmable-latency TX->RX loopback with link-down
// emulation, periodic encoding-error injection and a reported bitslide value.
module phy_loopback_emu #(
  parameter int unsigned g_data_width     = 8,
  parameter int unsigned g_max_delay      = 64,
  parameter int unsigned g_bitslide_width = 5
) (
  input  logic                            clk_sys,
  input  logic                            rst_n,
  input  logic [g_data_width-1:0]         tx_data_i,
  input  logic [g_data_width/8-1:0]       tx_k_i,
  output logic [g_data_width-1:0]         rx_data_o,
  output logic [g_data_width/8-1:0]       rx_k_o,
  output logic                            rx_enc_err_o,
  output logic [g_bitslide_width-1:0]     rx_bitslide_o,
  input  logic [1:0]                      cfg_mode_i,
  input  logic [$clog2(g_max_delay)-1:0]  cfg_delay_i,
  input  logic [15:0]                     cfg_err_period_i,
  input  logic [g_bitslide_width-1:0]     cfg_bitslide_i,
  input  logic                            cfg_update_i,
  output logic                            link_up_o,
  output logic [15:0]                     err_count_o
);

  localparam int unsigned DW = g_data_width;
  localparam int unsigned KW = g_data_width / 8;
  localparam int unsigned AW = $clog2(g_max_delay);
  localparam int unsigned WW = DW + KW;
  localparam int unsigned BW = g_bitslide_width;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_INJECT = 2'b11;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  // Latched configuration
  logic [1:0]    mode_q;
  logic [AW-1:0] delay_q;
  logic [15:0]   period_q;
  logic [BW-1:0] bitslide_q;

  // FSM, delay-line and injection state
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] fill_q, fill_d;
  logic [15:0]   per_q, per_d;
  logic [AW-1:0] wr_ptr_q;
  logic [WW-1:0] mem [g_max_delay];

  // Next-value of registered outputs
  logic [DW-1:0] rx_data_d;
  logic [KW-1:0] rx_k_d;
  logic          enc_err_d;
  logic [BW-1:0] bitslide_d;
  logic          link_up_d;
  logic [15:0]   err_count_d;

  logic [AW-1:0] delay_eff;
  logic [AW-1:0] rd_addr;
  logic [WW-1:0] rd_word;
  logic [DW-1:0] inj_mask;

  // Read side of the delay line; zero delay bypasses the RAM for 1-cycle latency
  always_comb begin
    delay_eff = (mode_q == MODE_BYPASS) ? '0 : delay_q;
    rd_addr   = wr_ptr_q - delay_eff;
    rd_word   = (delay_eff == '0) ? {tx_k_i, tx_data_i} : mem[rd_addr];
    inj_mask  = '0;
    for (int unsigned b = 0; b < KW; b++) begin
      inj_mask[8*b] = 1'b1;
    end
  end

  // Configuration latch, only on the update strobe
  always_ff @(posedge clk_sys or posedge rst_n) begin
    if (rst_n) begin
      mode_q     <= MODE_BYPASS;
      delay_q    <= '0;
      period_q   <= '0;
      bitslide_q <= '0;
    end else if (cfg_update_i) begin
      mode_q     <= cfg_mode_i;
      delay_q    <= cfg_delay_i;
      period_q   <= cfg_err_period_i;
      bitslide_q <= cfg_bitslide_i;
    end
  end

  // Delay-line RAM, written every cycle regardless of state
  always_ff @(posedge clk_sys) begin
    mem[wr_ptr_q] <= {tx_k_i, tx_data_i};
  end

  // Next-state, injection and output decode
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    per_d       = per_q;
    rx_data_d   = '0;
    rx_k_d      = '0;
    enc_err_d   = 1'b0;
    bitslide_d  = '0;
    link_up_d   = 1'b0;
    err_count_d = err_count_o;

    if (cfg_update_i) begin
      state_d = ST_FILL;
      fill_d  = '0;
      per_d   = '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (fill_q == delay_eff) begin
            fill_d  = '0;
            state_d = (mode_q == MODE_DOWN) ? ST_DOWN : ST_RUN;
          end else begin
            fill_d = fill_q + AW'(1);
          end
        end
        ST_RUN:  state_d = ST_RUN;
        ST_DOWN: state_d = ST_DOWN;
        default: state_d = ST_FILL;
      endcase
    end

    case (state_d)
      ST_RUN: begin
        rx_data_d  = rd_word[DW-1:0];
        rx_k_d     = rd_word[WW-1:DW];
        link_up_d  = 1'b1;
        bitslide_d = bitslide_q;
        if (mode_q == MODE_INJECT && period_q != 16'd0) begin
          if (per_q == period_q - 16'd1) begin
            per_d       = '0;
            rx_data_d   = rd_word[DW-1:0] ^ inj_mask;
            rx_k_d      = '0;
            enc_err_d   = 1'b1;
            err_count_d = (err_count_o == 16'hFFFF) ? err_count_o : err_count_o + 16'd1;
          end else begin
            per_d = per_q + 16'd1;
          end
        end
      end
      ST_DOWN: enc_err_d = 1'b1;
      default: ;
    endcase
  end

  // State, pointer and output registers
  always_ff @(posedge clk_sys or posedge rst_n) begin
    if (rst_n) begin
      state_q       <= ST_FILL;
      fill_q        <= '0;
      per_q         <= '0;
      wr_ptr_q      <= '0;
      rx_data_o     <= '0;
      rx_k_o        <= '0;
      rx_enc_err_o  <= 1'b0;
      rx_bitslide_o <= '0;
      link_up_o     <= 1'b0;
      err_count_o   <= '0;
    end else begin
      state_q       <= state_d;
      fill_q        <= fill_d;
      per_q         <= per_d;
      wr_ptr_q      <= wr_ptr_q + AW'(1);
      rx_data_o     <= rx_data_d;
      rx_k_o        <= rx_k_d;
      rx_enc_err_o  <= enc_err_d;
      rx_bitslide_o <= bitslide_d;
      link_up_o     <= link_up_d;
      err_count_o   <= err_count_d;
    end
  end

endmodule

// File: doc/phy_loopback_emu.md
Name: phy_loopback_emu

Overview:
Parametrised, synthesizable PHY loopback emulator for WR core simulation benches and FPGA self-test builds. It replaces the plain wire loopback of PHY TX to PHY RX. Features: programmable latency, 8- or 16-bit data paths, link-down emulation, periodic encoding-error injection, and reported bitslide. It sits between the wr_core PHY TX outputs and PHY RX inputs and is clocked by clk_sys (the reference/PHY clock domain).

Parameters:
g_data_width, 8, PHY data width; legal values 8 or 16; K/err lanes = g_data_width/8
g_max_delay, 64, delay-line depth in words; power of 2, min 2
g_bitslide_width, 5, width of reported bitslide value

Ports:
clk_sys  in  1  system/PHY clock, all logic rising-edge
rst_n  in  1  reset, asynchronous, active-high (asserted = 1)
tx_data_i  in  g_data_width  TX data from core
tx_k_i  in  g_data_width/8  TX K-flags, one per byte
rx_data_o  out  g_data_width  looped-back RX data
rx_k_o  out  g_data_width/8  looped-back K-flags
rx_enc_err_o  out  1  emulated encoding error
rx_bitslide_o  out  g_bitslide_width  emulated bitslide
cfg_mode_i  in  2  00 bypass, 01 delay, 10 link-down, 11 delay+error-inject
cfg_delay_i  in  log2(g_max_delay)  extra latency in words
cfg_err_period_i  in  16  injection period in words; 0 = none
cfg_bitslide_i  in  g_bitslide_width  bitslide value to report
cfg_update_i  in  1  single-cycle strobe; latches all cfg_* inputs
link_up_o  out  1  emulated link status
err_count_o  out  16  injected-error count, saturating

Behaviour:
- Reset: all outputs 0. Latched config resets to mode 00, delay 0, period 0, bitslide 0. State goes to FILL with fill counter 0; pointers and period counter are 0.
- Config is only used from latched registers. cfg_* inputs are ignored except on a cfg_update_i cycle.
- Delay line: circular RAM of g_max_delay words (data + K). It writes {tx_k_i, tx_data_i} every cycle in all states and modes. wr_ptr increments by 1 and wraps modulo g_max_delay. Read address = wr_ptr − delay (modulo). Output register follows the read.
- Latency TX→RX: delay+1 cycles in modes 01/11; 1 cycle in mode 00 (delay ignored). Max delay = g_max_delay−1.
- FSM states FILL, RUN, DOWN:
  - FILL: outputs data 0, K 0, enc_err 0, bitslide 0, link_up 0. Fill counter counts latched delay+1 cycles (mode 00: 1 cycle), then → RUN. In mode 10, → DOWN instead.
  - RUN: rx_data/rx_k come from the delay path. link_up_o = 1. rx_bitslide_o = latched bitslide.
  - DOWN (mode 10): rx_data 0, rx_k 0, rx_enc_err_o = 1 every cycle, link_up 0, bitslide 0.
  - cfg_update_i in any state → FILL, fill counter cleared, period counter cleared. New config takes effect the cycle after the strobe. cfg_update during FILL restarts FILL.
- Error injection (mode 11, RUN, period P ≠ 0):
  - Period counter increments per output word.
  - On the word where counter == P−1: invert bit 0 of every data byte, force that word's K bits to 0, assert rx_enc_err_o for that one cycle. Counter returns to 0.
  - err_count_o increments on each injected word and saturates at 0xFFFF.
  - P = 1 corrupts every word. Modes 00/01: never inject, enc_err 0.
- err_count_o is cleared only by reset, not by cfg_update.
- Reset asserted mid-operation: immediate asynchronous clear of outputs, pointers, counters and config. RAM contents are don't-care, because FILL masks stale words.
- Simultaneous cfg_update_i and a due injection: the update wins, no injection that cycle, and err_count does not increment.
- link_up_o changes only on the FSM transitions listed above; no glitches within RUN.

Test Plan:
- Reset, then mode 00 with incrementing bytes 0x00.. on tx_data_i → rx_data_o equals tx delayed 1 cycle; link_up_o = 1 from cycle 2; enc_err 0.
- cfg_update with mode 01, delay 10, g_data_width 16, K=2'b01 on 0xBC50 → link_up 0 for 11 cycles, then rx output equals tx stream with latency 11; K preserved per byte.
- Mode 11, delay 0, period 4, constant 0x55 → every 4th RX word is 0x54 with enc_err 1 and K 0; err_count increments by 1 per 4 words. Preset err_count to 0xFFFE via a long run → it stops at 0xFFFF.
- Mode 10 → rx_data 0, enc_err continuously 1, link_up 0. Switch back to mode 01, delay 3 → 4 FILL cycles, then RUN with correct data.
- cfg_update strobed twice, 2 cycles apart, during FILL with delay 63 → FILL restarts; link_up rises exactly 64 cycles after the second strobe. Pointer wrap is verified over more than 128 words with no data loss.
- Assert rst_n mid-RUN in mode 11 → all outputs 0 asynchronously, err_count 0, config back to mode 00.
